// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 receiver: register map, status bit positions,
// receiver state encoding and the parity helper.
package ps2_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int unsigned ST_RDA_BIT    = 0;
  localparam int unsigned ST_FULL_BIT   = 1;
  localparam int unsigned ST_OVR_BIT    = 2;
  localparam int unsigned ST_PAR_BIT    = 3;
  localparam int unsigned ST_FRM_BIT    = 4;
  localparam int unsigned ST_COUNT_LSB  = 8;

  localparam int unsigned CTRL_FLUSH_BIT = 0;
  localparam int unsigned CTRL_CLEAR_BIT = 1;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  localparam logic [1:0] S_IDLE   = RX_IDLE;
  localparam logic [1:0] S_DATA   = RX_DATA;
  localparam logic [1:0] S_PARITY = RX_PARITY;
  localparam logic [1:0] S_STOP   = RX_STOP;

  // Odd parity: the eight data bits plus the parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Byte FIFO for received PS/2 scan codes; simultaneous push/pop on a full
// FIFO succeeds, flush dominates both.
module ps2_rx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A pop frees the slot the same cycle, so a push into a full FIFO is accepted.
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & ~flush & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ps2_bus_rx.sv
// PS/2 device-to-host receiver with RX FIFO, sticky error flags and a tristate
// register port. Define PS2_RX_TIMEOUT_EN to abort frames stalled with ps2_clk high.
module ps2_bus_rx
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned BUS_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 5000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             we,
  input  logic [1:0]       addr,
  inout  wire  [BUS_W-1:0] DataBus,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic             rda
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic                   sclk, sdat, fall;

  logic [1:0]       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_ok_q, par_ok_d;
  logic             push_req, frm_set, par_set, ovr_set;

  logic             overrun_q, overrun_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;

  logic             rd_acc, wr_acc, pop, flush, clear;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic [15:0]      status_w;
  logic [BUS_W-1:0] rd_word;
  logic [BUS_W-1:0] bus_q, bus_d;
  logic             drive_q, drive_d;

  // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q <= sclk;
    end
  end

  assign sclk = clk_sync_q[SYNC_STAGES-1];
  assign sdat = dat_sync_q[SYNC_STAGES-1];
  assign fall = clk_prev_q & ~sclk;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC));

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == S_IDLE || !sclk) tmo_d = '0;
    else if (!tmo_hit)              tmo_d = tmo_q + TMO_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  // Frame receiver: advances on synchronised ps2_clk falling edges.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    push_req  = 1'b0;
    frm_set   = 1'b0;
    par_set   = 1'b0;
    if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (sdat) begin
            frm_set = 1'b1;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d   = {sdat, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_ok_d = odd_parity_ok(shift_q, sdat);
          state_d  = S_STOP;
        end
        S_STOP: begin
          if (!sdat)     frm_set  = 1'b1;
          if (!par_ok_q) par_set  = 1'b1;
          push_req = sdat & par_ok_q;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
`ifdef PS2_RX_TIMEOUT_EN
    if (tmo_hit) begin
      state_d = S_IDLE;
      frm_set = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_ok_q  <= par_ok_d;
    end
  end

  assign rd_acc = cs & ~we;
  assign wr_acc = cs & we;
  assign pop    = rd_acc & (addr == ADDR_DATA) & ~fifo_empty;
  assign flush  = wr_acc & (addr == ADDR_CTRL) & DataBus[CTRL_FLUSH_BIT];
  assign clear  = wr_acc & (addr == ADDR_CTRL) & DataBus[CTRL_CLEAR_BIT];

  ps2_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .flush (flush),
    .din   (shift_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A byte lost to flush is not an overrun; a same-cycle pop makes room.
  assign ovr_set = push_req & fifo_full & ~pop & ~flush;

  always_comb begin
    overrun_d    = (overrun_q    & ~clear) | ovr_set;
    parity_err_d = (parity_err_q & ~clear) | par_set;
    frame_err_d  = (frame_err_q  & ~clear) | frm_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rda = ~fifo_empty;

  always_comb begin
    status_w = '0;
    status_w[ST_RDA_BIT]  = ~fifo_empty;
    status_w[ST_FULL_BIT] = fifo_full;
    status_w[ST_OVR_BIT]  = overrun_q;
    status_w[ST_PAR_BIT]  = parity_err_q;
    status_w[ST_FRM_BIT]  = frame_err_q;
    status_w[15:ST_COUNT_LSB] = 8'(fifo_count);
  end

  always_comb begin
    rd_word = '0;
    case (addr)
      ADDR_DATA:   if (!fifo_empty) rd_word = BUS_W'({1'b1, 7'b0, fifo_dout});
      ADDR_STATUS: rd_word = BUS_W'(status_w);
      default:     rd_word = '0;
    endcase
  end

  // Read data is registered and driven onto the bus for the following cycle only.
  always_comb begin
    bus_d   = bus_q;
    drive_d = rd_acc;
    if (rd_acc) bus_d = rd_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_q   <= '0;
      drive_q <= 1'b0;
    end else begin
      bus_q   <= bus_d;
      drive_q <= drive_d;
    end
  end

  assign DataBus = drive_q ? bus_q : {BUS_W{1'bz}};

endmodule

// File: tb/tb_ps2_bus_rx.sv
// Directed bench for ps2_bus_rx: frames are bit-banged on ps2_clk/ps2_data and
// results are read back through the register port.
module tb_ps2_bus_rx;

  localparam int unsigned HALF = 8;
  localparam int unsigned TMO  = 5000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        rda;
  logic [15:0] tb_bus = 16'h0000;
  logic        tb_drv = 1'b0;
  wire  [15:0] DataBus;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  assign DataBus = tb_drv ? tb_bus : 16'bz;

  always #5 clk = ~clk;

  ps2_bus_rx #(
    .DEPTH       (8),
    .BUS_W       (16),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .DataBus  (DataBus),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rda      (rda)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
    d = DataBus;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; tb_drv = 1'b1; tb_bus = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; tb_drv = 1'b0;
  endtask

  // One PS/2 bit: data set while clock is high, then a low pulse.
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  // Full frame; optionally issues a DATA read landing on the stop-bit push cycle.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input logic pop_at_stop, output logic rda_at3,
                            output logic [15:0] popped);
    logic [9:0] fr;
    fr = {par, b, 1'b0};
    popped = 16'h0000;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) ps2_bit(fr[i]);
    ps2_data = stp;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    @(posedge clk);
    @(posedge clk);
    if (pop_at_stop) begin
      @(negedge clk);
      cs = 1'b1; we = 1'b0; addr = 2'd0;
    end
    @(posedge clk);
    #1 rda_at3 = rda;
    if (pop_at_stop) begin
      @(negedge clk);
      cs = 1'b0;
      popped = DataBus;
    end
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    logic        r;
    logic [15:0] p;
    send_frame(b, ~^b, 1'b1, 1'b0, r, p);
  endtask

  initial begin
    logic [15:0] d;
    logic        r;
    logic [15:0] p;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_rda", 16'(rda), 16'h0000);
    bus_read(2'd1, d); check("reset_status", d, 16'h0000);
    bus_read(2'd0, d); check("reset_data_empty", d, 16'h0000);

    // Clean 0x1C: parity bit 0 gives odd total.
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, r, p);
    check("1c_rda_latency", 16'(r), 16'h0001);
    bus_read(2'd0, d); check("1c_data", d, 16'h801C);
    #1 check("1c_rda_after_pop", 16'(rda), 16'h0000);
    bus_read(2'd1, d); check("1c_status", d, 16'h0000);

    // 0x55 with parity 0 (even total) is rejected.
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, r, p);
    check("par_no_push", 16'(r), 16'h0000);
    bus_read(2'd1, d); check("par_status", d, 16'h0008);
    bus_write(2'd2, 16'h0002);
    bus_read(2'd1, d); check("par_cleared", d, 16'h0000);

    // Nine frames into an 8-deep FIFO.
    for (int i = 0; i < 9; i++) send_good(8'hA0 + 8'(i));
    bus_read(2'd1, d); check("ovr_status", d, 16'h0807);
    for (int i = 0; i < 8; i++) begin
      bus_read(2'd0, d); check("ovr_data", d, 16'h80A0 + 16'(i));
    end
    bus_read(2'd0, d); check("ovr_data_empty", d, 16'h0000);
    bus_read(2'd1, d); check("ovr_sticky", d, 16'h0004);
    bus_write(2'd2, 16'h0002);

    // Full FIFO with a pop on the push cycle: no overrun, last byte kept.
    for (int i = 0; i < 8; i++) send_good(8'h30 + 8'(i));
    bus_read(2'd1, d); check("full_status", d, 16'h0803);
    send_frame(8'h38, ~^8'h38, 1'b1, 1'b1, r, p);
    check("simul_pop_data", p, 16'h8030);
    bus_read(2'd1, d); check("simul_status", d, 16'h0803);
    for (int i = 1; i < 9; i++) begin
      bus_read(2'd0, d); check("simul_drain", d, 16'h8030 + 16'(i));
    end
    bus_read(2'd1, d); check("simul_empty_status", d, 16'h0000);

    // Flush discards stored bytes.
    send_good(8'h11);
    send_good(8'h12);
    bus_read(2'd1, d); check("pre_flush_status", d, 16'h0201);
    bus_write(2'd2, 16'h0001);
    bus_read(2'd1, d); check("flush_status", d, 16'h0000);
    bus_read(2'd0, d); check("flush_data", d, 16'h0000);

    // Unused addresses read zero, do not pop, and ignore writes.
    send_good(8'h22);
    bus_read(2'd2, d); check("addr2_read", d, 16'h0000);
    bus_read(2'd3, d); check("addr3_read", d, 16'h0000);
    bus_write(2'd3, 16'h0003);
    bus_read(2'd1, d); check("addr3_no_effect", d, 16'h0101);
    bus_read(2'd0, d); check("addr3_data", d, 16'h8022);

    // Falling edge with data high while idle, then a bad stop bit.
    @(posedge clk); #1;
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (4) @(posedge clk);
    bus_read(2'd1, d); check("idle_frame_err", d, 16'h0010);
    bus_write(2'd2, 16'h0002);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, r, p);
    check("stop_no_push", 16'(r), 16'h0000);
    bus_read(2'd1, d); check("stop_frame_err", d, 16'h0010);
    bus_write(2'd2, 16'h0002);

    // Reset between data bits 3 and 4 drops the partial frame.
    @(posedge clk); #1;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    send_good(8'hF0);
    bus_read(2'd0, d); check("rst_mid_data", d, 16'h80F0);
    bus_read(2'd0, d); check("rst_mid_only_one", d, 16'h0000);
    bus_read(2'd1, d); check("rst_mid_status", d, 16'h0000);

`ifdef PS2_RX_TIMEOUT_EN
    // Stall high after five bits until the timeout aborts the frame.
    @(posedge clk); #1;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TMO + 20) @(posedge clk);
    bus_read(2'd1, d); check("tmo_frame_err", d, 16'h0010);
    bus_write(2'd2, 16'h0002);
    send_good(8'h12);
    bus_read(2'd0, d); check("tmo_next_frame", d, 16'h8012);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
